// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-oriented UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Bits per frame: start + 8 data + optional parity + stop bits.
  function automatic int frame_bits(input int parity, input int stop_bits);
    return 9 + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign count    = CW'(wr_ptr - rd_ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_word.sv
// UART transmitter taking multi-byte words through a FIFO; each word goes out
// as back-to-back frames, least-significant byte first.
module uart_tx_word
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int WORD_BYTES  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    tx,
  output logic                    busy,
  output logic [CW-1:0]           fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int W            = 8 * WORD_BYTES;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BYTE = 3'(WORD_BYTES - 1);
  localparam parity_t          PAR_MODE  = parity_t'(2'(PARITY));

  if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      WORD_BYTES < 1 || WORD_BYTES > 8 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $fatal(1, "uart_tx_word: illegal parameter combination");
  end

  tx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic             stop_idx;
  logic             par_acc;
  logic [W-1:0]     shreg;
  logic [W-1:0]     fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             bit_end;
  logic             last_stop;
  logic             word_done;

  assign bit_end   = (clk_cnt == CNT_MAX);
  assign last_stop = (STOP_BITS == 1) || stop_idx;
  assign word_done = (state == ST_STOP) && bit_end && last_stop && (byte_idx == LAST_BYTE);
  assign fifo_pop  = ((state == ST_IDLE) || word_done) && !fifo_empty;
  assign in_ready  = !fifo_full;

  uart_word_fifo #(
    .WIDTH(W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .push_data(in_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      stop_idx <= 1'b0;
      par_acc  <= 1'b0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      clk_cnt <= (state == ST_IDLE || bit_end) ? '0 : clk_cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg    <= fifo_data;
            byte_idx <= '0;
            state    <= ST_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            par_acc <= 1'b0;
            tx      <= shreg[0];
          end
        end
        ST_DATA: begin
          // The low byte of shreg is always the byte on the line; shifting
          // one bit per data bit leaves the next byte aligned after 8 bits.
          if (bit_end) begin
            par_acc <= par_acc ^ shreg[0];
            shreg   <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              if (PAR_MODE != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= par_acc ^ shreg[0] ^ (PAR_MODE == PAR_ODD);
              end else begin
                state    <= ST_STOP;
                stop_idx <= 1'b0;
                tx       <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_START;
              tx       <= 1'b0;
            end else if (!fifo_empty) begin
              shreg    <= fifo_data;
              byte_idx <= '0;
              state    <= ST_START;
              tx       <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_word.sv
// Scoreboard bench: three transmitter configurations, each decoded by a line monitor.
module tb_uart_tx_word;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        va, vb, vc;
  logic [31:0] da;
  logic [7:0]  db;
  logic [15:0] dc;
  logic        tx_a, tx_b, tx_c, busy_a, busy_b, busy_c, rdy_a, rdy_b, rdy_c;
  logic [2:0]  cnt_a, cnt_b, cnt_c;
  logic [2:0]  tx_v, busy_v, rdy_v;

  assign tx_v   = {tx_c, tx_b, tx_a};
  assign busy_v = {busy_c, busy_b, busy_a};
  assign rdy_v  = {rdy_c, rdy_b, rdy_a};

  // A: 4-byte words, no parity, 1 stop. B: 1 byte, even parity, 2 stop. C: 2 bytes, odd parity.
  uart_tx_word #(.CLK_FREQ_HZ(800), .BAUD_RATE(100), .WORD_BYTES(4), .FIFO_DEPTH(4),
                 .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .in_data(da), .in_valid(va), .in_ready(rdy_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));
  uart_tx_word #(.CLK_FREQ_HZ(800), .BAUD_RATE(100), .WORD_BYTES(1), .FIFO_DEPTH(4),
                 .PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .in_data(db), .in_valid(vb), .in_ready(rdy_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));
  uart_tx_word #(.CLK_FREQ_HZ(800), .BAUD_RATE(100), .WORD_BYTES(2), .FIFO_DEPTH(4),
                 .PARITY(2), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst), .in_data(dc), .in_valid(vc), .in_ready(rdy_c),
    .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c));

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q0[$], q1[$], q2[$];
  int rst_epoch = 0;
  bit gap_en = 1'b0;
  int run_b = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input int k, input logic [31:0] w);
    case (k)
      0:       for (int i = 0; i < 4; i++) q0.push_back(w[8*i +: 8]);
      1:       q1.push_back(w[7:0]);
      default: for (int i = 0; i < 2; i++) q2.push_back(w[8*i +: 8]);
    endcase
  endtask

  task automatic push(input int k, input logic [31:0] w, output bit acc);
    @(negedge clk);
    case (k)
      0:       begin va = 1'b1; da = w; end
      1:       begin vb = 1'b1; db = w[7:0]; end
      default: begin vc = 1'b1; dc = w[15:0]; end
    endcase
    acc = rdy_v[k];
    @(posedge clk);
    #1;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    if (acc) sb_push(k, w);
  endtask

  // Samples each bit at its midpoint and compares against the scoreboard.
  task automatic monitor(input int k);
    int npar, nstop, ep, have;
    logic odd, start_ok, stop_ok, p;
    logic [7:0] d, e;
    npar  = (k == 0) ? 0 : 1;
    nstop = (k == 1) ? 2 : 1;
    odd   = (k == 2);
    forever begin
      @(negedge clk);
      if (tx_v[k] == 1'b0) begin
        ep = rst_epoch;
        repeat (4) @(negedge clk);
        start_ok = (tx_v[k] == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          d[i] = tx_v[k];
        end
        p = 1'b0;
        if (npar != 0) begin
          repeat (8) @(negedge clk);
          p = tx_v[k];
        end
        stop_ok = 1'b1;
        for (int s = 0; s < nstop; s++) begin
          repeat (8) @(negedge clk);
          if (tx_v[k] !== 1'b1) stop_ok = 1'b0;
        end
        if (ep == rst_epoch) begin
          check_val($sformatf("start_bit_%0d", k), start_ok, 1);
          check_val($sformatf("stop_bits_%0d", k), stop_ok, 1);
          have = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
          check_val($sformatf("frame_expected_%0d", k), (have > 0), 1);
          if (have > 0) begin
            case (k)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            check_val($sformatf("byte_%0d", k), d, e);
            if (npar != 0) check_val($sformatf("parity_%0d", k), p, (^e) ^ odd);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // Line-high run between consecutive frames of instance B.
  always @(negedge clk) begin
    if (!busy_v[1]) run_b = 0;
    else if (tx_v[1]) run_b = run_b + 1;
    else begin
      if (gap_en && run_b > 0) check_val("stop_gap", run_b, 16);
      run_b = 0;
    end
  end

  task automatic measure_busy(input int k, input int exp, input string tag);
    int n, w;
    n = 0;
    w = 0;
    while (!busy_v[k] && w < 100) begin @(posedge clk); #1; w++; end
    while (busy_v[k] && n < 5000) begin n++; @(posedge clk); #1; end
    check_val(tag, n, exp);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy_v != 3'b000 || (q0.size() + q1.size() + q2.size()) != 0) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    check_val("drain", (n < limit), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, lows, highs, nacc;
    va = 1'b0; vb = 1'b0; vc = 1'b0; da = '0; db = '0; dc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tx", tx_v, 3'b111);
    check_val("rst_busy", busy_v, 3'b000);
    check_val("rst_ready", rdy_v, 3'b111);
    check_val("rst_count", {cnt_a, cnt_b, cnt_c}, 9'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single word on A: latency and busy length.
    push(0, 32'h44332211, acc);
    check_val("a_count_after_accept", cnt_a, 1);
    check_val("a_tx_before_pop", tx_v[0], 1);
    @(posedge clk);
    #1;
    check_val("a_tx_start", tx_v[0], 0);
    check_val("a_busy_start", busy_v[0], 1);
    check_val("a_count_after_pop", cnt_a, 0);
    n = 0;
    while (busy_v[0] && n < 1000) begin n++; @(posedge clk); #1; end
    check_val("a_busy_len", n, 320);
    wait_idle(200);

    // Parity modes.
    push(1, 32'h07, acc);
    measure_busy(1, 96, "b_busy_len");
    wait_idle(200);
    push(1, 32'h00, acc);
    wait_idle(300);
    push(2, 32'h0007, acc);
    measure_busy(2, 176, "c_busy_len");
    wait_idle(200);

    // Two words back-to-back on B: 16-cycle stop gap, no idle between words.
    gap_en = 1'b1;
    push(1, 32'h00, acc);
    push(1, 32'h80, acc);
    measure_busy(1, 192, "b_two_word_busy");
    wait_idle(200);
    gap_en = 1'b0;

    // Fill the FIFO on A with valid held every cycle.
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      push(0, 32'h10203040 + 32'(i) * 32'h01010101, acc);
      nacc += int'(acc);
    end
    check_val("a_accepted", nacc, 5);
    check_val("a_ready_full", rdy_v[0], 0);
    check_val("a_count_full", cnt_a, 4);
    n = 0;
    while (!rdy_v[0] && n < 400) begin @(posedge clk); #1; n++; end
    check_val("a_ready_return", rdy_v[0], 1);
    check_val("a_ready_return_cycle", n, 316);
    check_val("a_count_after_next_pop", cnt_a, 3);
    // Next pop edge is exactly one word later; push on that very edge.
    repeat (319) @(posedge clk);
    #1;
    check_val("a_count_pre_simul", cnt_a, 3);
    push(0, 32'hCAFEF00D, acc);
    check_val("a_simul_accept", acc, 1);
    check_val("a_count_simul", cnt_a, 3);
    wait_idle(3000);

    // Reset in the middle of byte 2 with 3 words queued.
    for (int i = 0; i < 4; i++) push(0, 32'hA0B0C0D0 ^ 32'(i), acc);
    check_val("a_count_queued", cnt_a, 3);
    repeat (195) @(posedge clk);
    #3;
    check_val("a_busy_before_rst", busy_v[0], 1);
    rst = 1'b1;
    rst_epoch++;
    q0.delete();
    #1;
    check_val("a_rst_tx", tx_v[0], 1);
    check_val("a_rst_busy", busy_v[0], 0);
    check_val("a_rst_count", cnt_a, 0);
    check_val("a_rst_ready", rdy_v[0], 1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx_v[0] == 1'b0) lows++;
      if (busy_v[0]) highs++;
    end
    check_val("a_idle_after_rst_tx", lows, 0);
    check_val("a_idle_after_rst_busy", highs, 0);
    push(0, 32'h5A6B7C8D, acc);
    measure_busy(0, 320, "a_busy_after_rst");
    wait_idle(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
